spi_4094_tx: RTL

SPI_4094_TX -- requirements
Module: spi_4094_tx

---
 rtl/spi_4094_tx.sv | 118 +++++++++++
 1 files changed

// File: rtl/spi_4094_tx.sv
// rtl/spi_4094_tx.sv - serial loader for a chain of CD4094 shift/latch registers
module spi_4094_tx #(
    parameter int NUM_BITS = 24,
    parameter int CLK_DIV  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [NUM_BITS-1:0] data,
    output logic                busy,
    output logic                done,
    output logic                sclk,
    output logic                sdata,
    output logic                strobe,
    output logic                oe
);
    localparam int               CNT_W      = $clog2(NUM_BITS + 1);
    localparam logic [7:0]       DIV_RELOAD = 8'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(NUM_BITS - 1);

    typedef enum logic [2:0] {IDLE, LOW, HIGH, STROBE, DONE} state_t;

    state_t              state_q;
    logic [7:0]          div_q;
    logic [CNT_W-1:0]    bit_cnt_q;
    logic [NUM_BITS-1:0] shift_q;
    logic [NUM_BITS-1:0] shift_d;
    logic                busy_q, done_q, sclk_q, sdata_q, strobe_q, oe_q;

    assign shift_d = shift_q << 1;

    assign busy   = busy_q;
    assign done   = done_q;
    assign sclk   = sclk_q;
    assign sdata  = sdata_q;
    assign strobe = strobe_q;
    assign oe     = oe_q;

    // Outputs are assigned for the state being entered, so they change with the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            div_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sclk_q    <= 1'b0;
            sdata_q   <= 1'b0;
            strobe_q  <= 1'b0;
            oe_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    div_q <= DIV_RELOAD;
                    if (start) begin
                        state_q   <= LOW;
                        shift_q   <= data;
                        bit_cnt_q <= '0;
                        busy_q    <= 1'b1;
                        sdata_q   <= data[NUM_BITS-1];
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        sdata_q <= 1'b0;
                    end
                end
                LOW: begin
                    if (div_q == 8'd0) begin
                        state_q <= HIGH;
                        div_q   <= DIV_RELOAD;
                        sclk_q  <= 1'b1;
                    end else begin
                        div_q <= div_q - 8'd1;
                    end
                end
                HIGH: begin
                    if (div_q == 8'd0) begin
                        div_q     <= DIV_RELOAD;
                        shift_q   <= shift_d;
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        sclk_q    <= 1'b0;
                        if (bit_cnt_q == LAST_BIT) begin
                            state_q  <= STROBE;
                            sdata_q  <= 1'b0;
                            strobe_q <= 1'b1;
                        end else begin
                            state_q <= LOW;
                            sdata_q <= shift_d[NUM_BITS-1];
                        end
                    end else begin
                        div_q <= div_q - 8'd1;
                    end
                end
                STROBE: begin
                    if (div_q == 8'd0) begin
                        state_q  <= DONE;
                        div_q    <= DIV_RELOAD;
                        strobe_q <= 1'b0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        // Outputs are enabled only once the latches hold a word we wrote.
                        oe_q     <= 1'b1;
                    end else begin
                        div_q <= div_q - 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    sclk_q  <= 1'b0;
                    sdata_q <= 1'b0;
                end
            endcase
        end
    end
endmodule
